// File: rtl/shift_exec_pkg.sv
// rtl/shift_exec_pkg.sv - shared types, constants and helpers for the shift execution stage
package shift_exec_pkg;

  localparam int XLEN_C = 32;

  typedef enum logic [2:0] {
    SHIFT_SLL = 3'd0,
    SHIFT_SRL = 3'd1,
    SHIFT_SRA = 3'd2,
    SHIFT_ROL = 3'd3,
    SHIFT_ROR = 3'd4
  } shift_op_e;

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/rshifter32.sv
// rtl/rshifter32.sv - 32-bit logical right shifter with optional rotate
module rshifter32 (
  input  logic [31:0] data_i,
  input  logic [4:0]  shamt_i,
  input  logic        rotate_en_i,
  output logic [31:0] data_o
);

  logic [31:0] wrap;

  // A zero amount shifts the wrap term out entirely, so rotate by 0 is a pass-through.
  always_comb begin
    wrap   = rotate_en_i ? (data_i << (6'd32 - {1'b0, shamt_i})) : 32'd0;
    data_o = (data_i >> shamt_i) | wrap;
  end

endmodule

// File: rtl/shift_exec_stage.sv
// rtl/shift_exec_stage.sv - two-stage valid/ready shift execution unit (SLL/SRL/SRA/ROL/ROR)
module shift_exec_stage
  import shift_exec_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int XLEN  = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       in_op_i,
  input  logic [XLEN-1:0]  in_data_i,
  input  logic [4:0]       in_shamt_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  out_result_o,
  output logic [TAG_W-1:0] out_tag_o,
  output logic             out_err_o
);

  if (XLEN != XLEN_C) begin : g_bad_xlen
    $error("shift_exec_stage: XLEN must be 32");
  end

  logic             a_valid_q, a_valid_d;
  logic [2:0]       a_op_q, a_op_d;
  logic [XLEN-1:0]  a_data_q, a_data_d;
  logic [4:0]       a_shamt_q, a_shamt_d;
  logic [TAG_W-1:0] a_tag_q, a_tag_d;

  logic             b_valid_q, b_valid_d;
  logic [XLEN-1:0]  b_result_q, b_result_d;
  logic [TAG_W-1:0] b_tag_q, b_tag_d;
  logic             b_err_q, b_err_d;

  logic b_free, a_adv, accept;

  always_comb begin
    b_free     = !b_valid_q || out_ready_i;
    a_adv      = a_valid_q && b_free;
    in_ready_o = (!a_valid_q || b_free) && !flush_i;
    accept     = in_valid_i && in_ready_o;
  end

  logic        is_rot;
  logic [31:0] a_rev, main_in, main_out, mask_out, comp_out;
  logic [4:0]  rot_amt, main_amt, comp_amt;
  logic [31:0] calc_result;
  logic        calc_err;

  // Rotates become right rotates: ROL by n is ROR by (32-n)&31, i.e. -n mod 32.
  always_comb begin
    is_rot   = (a_op_q == SHIFT_ROL) || (a_op_q == SHIFT_ROR);
    a_rev    = bitrev32(a_data_q);
    rot_amt  = (a_op_q == SHIFT_ROL) ? (5'd0 - a_shamt_q) : a_shamt_q;
    main_in  = (a_op_q == SHIFT_SLL) ? a_rev : a_data_q;
    main_amt = is_rot ? rot_amt : a_shamt_q;
    comp_amt = 5'd0 - rot_amt;
  end

  rshifter32 u_main (
    .data_i      (main_in),
    .shamt_i     (main_amt),
    .rotate_en_i (1'b0),
    .data_o      (main_out)
  );

  rshifter32 u_sra_mask (
    .data_i      (32'hFFFF_FFFF),
    .shamt_i     (a_shamt_q),
    .rotate_en_i (1'b0),
    .data_o      (mask_out)
  );

  // Left half of a rotate, computed as a reversed right shift.
  rshifter32 u_rot_comp (
    .data_i      (a_rev),
    .shamt_i     (comp_amt),
    .rotate_en_i (1'b0),
    .data_o      (comp_out)
  );

  always_comb begin
    calc_result = 32'd0;
    calc_err    = 1'b0;
    case (a_op_q)
      SHIFT_SRL: calc_result = main_out;
      SHIFT_SRA: calc_result = main_out | (a_data_q[31] ? ~mask_out : 32'd0);
      SHIFT_SLL: calc_result = bitrev32(main_out);
      SHIFT_ROL,
      SHIFT_ROR: calc_result = (rot_amt == 5'd0) ? a_data_q : (main_out | bitrev32(comp_out));
      default:   calc_err    = 1'b1;
    endcase
  end

  always_comb begin
    a_valid_d  = a_valid_q;
    a_op_d     = a_op_q;
    a_data_d   = a_data_q;
    a_shamt_d  = a_shamt_q;
    a_tag_d    = a_tag_q;
    b_valid_d  = b_valid_q;
    b_result_d = b_result_q;
    b_tag_d    = b_tag_q;
    b_err_d    = b_err_q;

    if (flush_i) begin
      a_valid_d = 1'b0;
      b_valid_d = 1'b0;
    end else begin
      if (accept) begin
        a_valid_d = 1'b1;
        a_op_d    = in_op_i;
        a_data_d  = in_data_i;
        a_shamt_d = in_shamt_i;
        a_tag_d   = in_tag_i;
      end else if (a_adv) begin
        a_valid_d = 1'b0;
      end

      if (a_adv) begin
        b_valid_d  = 1'b1;
        b_result_d = calc_result;
        b_tag_d    = a_tag_q;
        b_err_d    = calc_err;
      end else if (b_valid_q && out_ready_i) begin
        b_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_valid_q  <= 1'b0;
      a_op_q     <= '0;
      a_data_q   <= '0;
      a_shamt_q  <= '0;
      a_tag_q    <= '0;
      b_valid_q  <= 1'b0;
      b_result_q <= '0;
      b_tag_q    <= '0;
      b_err_q    <= 1'b0;
    end else begin
      a_valid_q  <= a_valid_d;
      a_op_q     <= a_op_d;
      a_data_q   <= a_data_d;
      a_shamt_q  <= a_shamt_d;
      a_tag_q    <= a_tag_d;
      b_valid_q  <= b_valid_d;
      b_result_q <= b_result_d;
      b_tag_q    <= b_tag_d;
      b_err_q    <= b_err_d;
    end
  end

  assign out_valid_o  = b_valid_q;
  assign out_result_o = b_result_q;
  assign out_tag_o    = b_tag_q;
  assign out_err_o    = b_err_q;

endmodule

// File: tb/tb_shift_exec_stage.sv
// tb/tb_shift_exec_stage.sv - randomized and directed bench for shift_exec_stage against a queue model
module tb_shift_exec_stage;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [2:0]  in_op_i;
  logic [31:0] in_data_i;
  logic [4:0]  in_shamt_i;
  logic [3:0]  in_tag_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_result_o;
  logic [3:0]  out_tag_o;
  logic        out_err_o;

  always #5 clk_i = ~clk_i;

  shift_exec_stage #(.TAG_W(4), .XLEN(32)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_op_i      (in_op_i),
    .in_data_i    (in_data_i),
    .in_shamt_i   (in_shamt_i),
    .in_tag_i     (in_tag_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_result_o (out_result_o),
    .out_tag_o    (out_tag_o),
    .out_err_o    (out_err_o)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  tag;
    logic        err;
    bit          shown;
  } ent_t;

  ent_t       q[$];
  logic [3:0] popped_tags[$];

  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] d, input logic [4:0] n);
    int sh;
    sh = int'(n);
    case (op)
      3'd0: return d << sh;
      3'd1: return d >> sh;
      3'd2: return 32'($signed(d) >>> sh);
      3'd3: return (sh == 0) ? d : ((d << sh) | (d >> (32 - sh)));
      3'd4: return (sh == 0) ? d : ((d >> sh) | (d << (32 - sh)));
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare DUT against the model, then advance the model at the edge.
  task automatic step(input bit v, input logic [2:0] op, input logic [31:0] d, input logic [4:0] n,
                      input logic [3:0] tag, input bit ordy, input bit fl, output bit accepted);
    bit exp_ov, a_exists, b_free, exp_ir, popped;
    ent_t e;
    @(negedge clk_i);
    in_valid_i  = v;
    in_op_i     = op;
    in_data_i   = d;
    in_shamt_i  = n;
    in_tag_i    = tag;
    out_ready_i = ordy;
    flush_i     = fl;
    #1;
    exp_ov   = (q.size() > 0) && q[0].shown;
    a_exists = (q.size() == 2) || (q.size() == 1 && !q[0].shown);
    b_free   = !exp_ov || ordy;
    exp_ir   = (!a_exists || b_free) && !fl;
    chk("out_valid", 32'(out_valid_o), 32'(exp_ov));
    chk("in_ready", 32'(in_ready_o), 32'(exp_ir));
    if (exp_ov) begin
      chk("out_result", out_result_o, q[0].res);
      chk("out_tag", 32'(out_tag_o), 32'(q[0].tag));
      chk("out_err", 32'(out_err_o), 32'(q[0].err));
    end
    accepted = v && exp_ir;
    @(posedge clk_i);
    if (fl) begin
      q.delete();
    end else begin
      popped = exp_ov && ordy;
      if (popped) begin
        popped_tags.push_back(q[0].tag);
        void'(q.pop_front());
      end
      if (q.size() > 0 && !q[q.size()-1].shown && b_free) q[q.size()-1].shown = 1'b1;
      if (accepted) begin
        e.res   = ref_res(op, d, n);
        e.tag   = tag;
        e.err   = (op > 3'd4);
        e.shown = 1'b0;
        q.push_back(e);
      end
    end
  endtask

  task automatic idle(input bit ordy);
    bit acc;
    step(1'b0, 3'd0, 32'd0, 5'd0, 4'd0, ordy, 1'b0, acc);
  endtask

  // Issue one request into an empty pipe with the consumer ready; check the result one edge after stage A fills.
  task automatic run_single(input string name, input logic [2:0] op, input logic [31:0] d,
                            input logic [4:0] n, input logic [3:0] tag,
                            input logic [31:0] exp_res, input logic exp_err);
    bit acc;
    step(1'b1, op, d, n, tag, 1'b1, 1'b0, acc);
    chk({name, "_acc"}, 32'(acc), 32'd1);
    #1;
    chk({name, "_lat_a"}, 32'(out_valid_o), 32'd0);
    idle(1'b1);
    #1;
    chk({name, "_lat_b"}, 32'(out_valid_o), 32'd1);
    chk({name, "_res"}, out_result_o, exp_res);
    chk({name, "_tag"}, 32'(out_tag_o), 32'(tag));
    chk({name, "_err"}, 32'(out_err_o), 32'(exp_err));
    idle(1'b1);
  endtask

  initial begin
    bit          acc;
    int          issued;
    int          budget;
    logic [31:0] held;

    rst_ni = 1'b0;
    flush_i = 1'b0; in_valid_i = 1'b0; in_op_i = 3'd0; in_data_i = 32'd0;
    in_shamt_i = 5'd0; in_tag_i = 4'd0; out_ready_i = 1'b0;
    #12;
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_result", out_result_o, 32'd0);
    chk("rst_tag", 32'(out_tag_o), 32'd0);
    chk("rst_err", 32'(out_err_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    chk("model_sra", ref_res(3'd2, 32'h8000_0000, 5'd4), 32'hF800_0000);
    chk("model_rol", ref_res(3'd3, 32'h8000_0001, 5'd1), 32'h0000_0003);
    chk("model_sll", ref_res(3'd0, 32'h0000_0001, 5'd31), 32'h8000_0000);

    run_single("srl31", 3'd1, 32'h8000_0000, 5'd31, 4'd3, 32'h0000_0001, 1'b0);
    run_single("sra4", 3'd2, 32'h8000_0000, 5'd4, 4'd1, 32'hF800_0000, 1'b0);
    run_single("sra31", 3'd2, 32'h7FFF_FFFF, 5'd31, 4'd2, 32'h0000_0000, 1'b0);
    run_single("sra0", 3'd2, 32'hFFFF_FFFF, 5'd0, 4'd4, 32'hFFFF_FFFF, 1'b0);
    run_single("sll31", 3'd0, 32'h0000_0001, 5'd31, 4'd5, 32'h8000_0000, 1'b0);
    run_single("rol1", 3'd3, 32'h8000_0001, 5'd1, 4'd6, 32'h0000_0003, 1'b0);
    run_single("ror1", 3'd4, 32'h0000_0001, 5'd1, 4'd7, 32'h8000_0000, 1'b0);
    run_single("ror0", 3'd4, 32'h1234_5678, 5'd0, 4'd8, 32'h1234_5678, 1'b0);
    run_single("rol0", 3'd3, 32'hA5A5_0F0F, 5'd0, 4'd9, 32'hA5A5_0F0F, 1'b0);
    run_single("sll0", 3'd0, 32'hCAFE_F00D, 5'd0, 4'd10, 32'hCAFE_F00D, 1'b0);

    // Backpressure: four tags, consumer stalled for five cycles.
    popped_tags.delete();
    issued = 0;
    held = 32'd0;
    for (int c = 0; c < 5; c++) begin
      step(issued < 4, 3'd1, 32'h100 << issued, 5'd4, 4'(issued), 1'b0, 1'b0, acc);
      if (acc) issued++;
      if (c == 2) held = out_result_o;
      if (c == 4) chk("bp_stable", out_result_o, held);
    end
    chk("bp_accepts", 32'(issued), 32'd2);
    budget = 0;
    while ((issued < 4 || q.size() > 0) && budget < 50) begin
      step(issued < 4, 3'd1, 32'h100 << issued, 5'd4, 4'(issued), 1'b1, 1'b0, acc);
      if (acc) issued++;
      budget++;
    end
    chk("bp_drain_budget", 32'(budget < 50), 32'd1);
    chk("bp_count", 32'(popped_tags.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < popped_tags.size()) chk("bp_order", 32'(popped_tags[i]), 32'(i));
    end

    // Flush with both stages occupied and a request pending.
    step(1'b1, 3'd0, 32'h1, 5'd1, 4'd11, 1'b0, 1'b0, acc);
    step(1'b1, 3'd0, 32'h2, 5'd1, 4'd12, 1'b0, 1'b0, acc);
    step(1'b1, 3'd0, 32'h3, 5'd1, 4'd13, 1'b1, 1'b1, acc);
    chk("flush_no_accept", 32'(acc), 32'd0);
    #1;
    chk("flush_valid", 32'(out_valid_o), 32'd0);
    idle(1'b1);
    #1;
    chk("flush_ready_after", 32'(in_ready_o), 32'd1);

    run_single("illegal7", 3'd7, 32'hDEAD_BEEF, 5'd3, 4'd14, 32'd0, 1'b1);

    // Randomized traffic including illegal ops, zero amounts, stalls and flushes.
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] n;
      n = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom, n, 4'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, acc);
    end

    // Asynchronous reset in the middle of traffic.
    step(1'b1, 3'd1, 32'hFFFF_0000, 5'd8, 4'd1, 1'b0, 1'b0, acc);
    step(1'b1, 3'd2, 32'h8000_0000, 5'd2, 4'd2, 1'b0, 1'b0, acc);
    #3;
    rst_ni = 1'b0;
    #1;
    chk("mrst_valid", 32'(out_valid_o), 32'd0);
    chk("mrst_result", out_result_o, 32'd0);
    chk("mrst_tag", 32'(out_tag_o), 32'd0);
    chk("mrst_err", 32'(out_err_o), 32'd0);
    q.delete();
    @(negedge clk_i);
    in_valid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
